// File: rtl/alu_op_sequencer_pkg.sv
// Shared opcode, FSM-state and decode definitions for the ALU operation sequencer.
package alu_op_sequencer_pkg;

    localparam int unsigned OP_ADD   = 0;
    localparam int unsigned OP_SUB   = 1;
    localparam int unsigned OP_AND   = 2;
    localparam int unsigned OP_OR    = 3;
    localparam int unsigned OP_SHR   = 4;
    localparam int unsigned OP_SHRA  = 5;
    localparam int unsigned OP_SHL   = 6;
    localparam int unsigned OP_ROR   = 7;
    localparam int unsigned OP_ROL   = 8;
    localparam int unsigned OP_MUL   = 9;
    localparam int unsigned OP_DIV   = 10;
    localparam int unsigned OP_NEG   = 11;
    localparam int unsigned OP_NOT   = 12;
    localparam int unsigned OP_COUNT = 13;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    function automatic logic is_multicycle(input int unsigned op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// Multi-cycle ALU controller: valid/ready request in, registered ALU drive, HI/LO response out.
// Optional ALU_SEQ_ILLEGAL_TRAP_EN adds rsp_err and short-circuits opcodes >= OP_COUNT.
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned SEL_W         = 5,
    parameter int unsigned MULDIV_CYCLES = 4
) (
    input  logic                clk,
    input  logic                clr_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [SEL_W-1:0]    req_op,
    input  logic [DATA_W-1:0]   req_a,
    input  logic [DATA_W-1:0]   req_b,
    output logic [DATA_W-1:0]   alu_a,
    output logic [DATA_W-1:0]   alu_b,
    output logic [SEL_W-1:0]    alu_sel,
    input  logic [2*DATA_W-1:0] alu_res,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_lo,
    output logic [DATA_W-1:0]   rsp_hi,
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    output logic                rsp_err,
`endif
    output logic                busy
);

    localparam int unsigned CNT_W = 4;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept, capture, illegal;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        capture = 1'b0;
        illegal = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
                    if (32'(req_op) >= OP_COUNT) begin
                        illegal = 1'b1;
                        state_d = ST_DONE;
                    end else
`endif
                    begin
                        accept  = 1'b1;
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                if (is_multicycle(32'(alu_sel)) && (MULDIV_CYCLES > 1)) begin
                    cnt_d   = CNT_W'(MULDIV_CYCLES - 2);
                    state_d = ST_WAIT;
                end else begin
                    capture = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    capture = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_sel <= '0;
            rsp_lo  <= '0;
            rsp_hi  <= '0;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
            rsp_err <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            // ALU inputs only move on accept so the ALU never sees a mid-op change
            if (accept) begin
                alu_a   <= req_a;
                alu_b   <= req_b;
                alu_sel <= req_op;
            end
            if (capture) begin
                rsp_lo <= alu_res[DATA_W-1:0];
                rsp_hi <= alu_res[2*DATA_W-1:DATA_W];
            end
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
            if (illegal) begin
                rsp_lo  <= '0;
                rsp_hi  <= '0;
                rsp_err <= 1'b1;
            end else if ((state_q == ST_DONE) && rsp_ready) begin
                rsp_err <= 1'b0;
            end
`endif
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_valid = (state_q == ST_DONE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer with a behavioural ALU on the alu_* side.
// Honours ALU_SEQ_ILLEGAL_TRAP_EN for the rsp_err port and illegal-opcode expectations.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [4:0]  req_op = '0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic [31:0] alu_a, alu_b;
    logic [4:0]  alu_sel;
    logic [63:0] alu_res;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_lo, rsp_hi;
    logic        busy;
    logic        err_bit;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    logic        rsp_err;
    assign err_bit = rsp_err;
`else
    assign err_bit = 1'b0;
`endif

    alu_op_sequencer #(
        .DATA_W(32), .SEL_W(5), .MULDIV_CYCLES(4)
    ) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_res   (alu_res),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_lo    (rsp_lo),
        .rsp_hi    (rsp_hi),
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
        .rsp_err   (rsp_err),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU; single-cycle ops drive a recognisable HI pattern to prove pass-through
    always_comb begin
        logic [4:0]  sh;
        logic [63:0] dbl;
        sh      = alu_b[4:0];
        dbl     = '0;
        alu_res = {16'hC0DE, 11'd0, alu_sel, 32'h0};
        case (alu_sel)
            5'd0:  alu_res[31:0] = alu_a + alu_b;
            5'd1:  alu_res[31:0] = alu_a - alu_b;
            5'd2:  alu_res[31:0] = alu_a & alu_b;
            5'd3:  alu_res[31:0] = alu_a | alu_b;
            5'd4:  alu_res[31:0] = alu_a >> sh;
            5'd5:  alu_res[31:0] = $signed(alu_a) >>> sh;
            5'd6:  alu_res[31:0] = alu_a << sh;
            5'd7:  begin dbl = {alu_a, alu_a} >> sh; alu_res[31:0] = dbl[31:0]; end
            5'd8:  begin dbl = {alu_a, alu_a} << sh; alu_res[31:0] = dbl[63:32]; end
            5'd9:  alu_res = 64'(alu_a) * 64'(alu_b);
            5'd10: alu_res = (alu_b == 0) ? {alu_a, 32'hFFFF_FFFF} : {alu_a % alu_b, alu_a / alu_b};
            5'd11: alu_res[31:0] = -alu_a;
            5'd12: alu_res[31:0] = ~alu_a;
            default: alu_res[31:0] = 32'hDEAD_BEEF;
        endcase
    end

    int n_checks = 0;
    int n_fail = 0;
    int acc_cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_req(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_seen", req_ready, 1);
        @(posedge clk);
        #1;
        acc_cyc   = cyc;
        req_valid = 1'b0;
    endtask

    // Latency counts negedges after the accept edge until rsp_valid is observed
    task automatic wait_rsp(output int lat);
        int bad = 0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!rsp_valid && (!busy || req_ready)) bad++;
        end while (!rsp_valid && lat < 40);
        check("busy_while_pending", bad, 0);
        check("rsp_valid_arrives", rsp_valid, 1);
    endtask

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
        int          lat;
        logic        err;
    } vec_t;

    vec_t vecs[16];

    initial begin
        int          lat;
        int          prev_acc;
        logic [4:0]  prev_sel, exp_sel;
        logic [31:0] prev_a, exp_a, held_lo;

        vecs[0]  = '{5'd0,  32'd5,          32'd2,          32'd7,          32'hC0DE_0000, 2, 1'b0};
        vecs[1]  = '{5'd3,  32'h0000_00F0,  32'h0000_0F0F,  32'h0000_0FFF,  32'hC0DE_0003, 2, 1'b0};
        vecs[2]  = '{5'd9,  32'h0001_0000,  32'h0001_0000,  32'h0,          32'h1,         5, 1'b0};
        vecs[3]  = '{5'd6,  32'h1,          32'd31,         32'h8000_0000,  32'hC0DE_0006, 2, 1'b0};
        vecs[4]  = '{5'd1,  32'd2,          32'd5,          32'hFFFF_FFFD,  32'hC0DE_0001, 2, 1'b0};
        vecs[5]  = '{5'd2,  32'hF0F0_1234,  32'h0FF0_FF00,  32'h00F0_1200,  32'hC0DE_0002, 2, 1'b0};
        vecs[6]  = '{5'd4,  32'h8000_0000,  32'd4,          32'h0800_0000,  32'hC0DE_0004, 2, 1'b0};
        vecs[7]  = '{5'd5,  32'h8000_0000,  32'd4,          32'hF800_0000,  32'hC0DE_0005, 2, 1'b0};
        vecs[8]  = '{5'd7,  32'h1,          32'd1,          32'h8000_0000,  32'hC0DE_0007, 2, 1'b0};
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
        vecs[9]  = '{5'd31, 32'h1234_5678,  32'h9ABC_DEF0,  32'h0,          32'h0,         1, 1'b1};
`else
        vecs[9]  = '{5'd31, 32'h1234_5678,  32'h9ABC_DEF0,  32'hDEAD_BEEF,  32'hC0DE_001F, 2, 1'b0};
`endif
        vecs[10] = '{5'd8,  32'h8000_0001,  32'd4,          32'h0000_0018,  32'hC0DE_0008, 2, 1'b0};
        vecs[11] = '{5'd9,  32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFE,  32'h1,         5, 1'b0};
        vecs[12] = '{5'd10, 32'd100,        32'd7,          32'd14,         32'd2,         5, 1'b0};
        vecs[13] = '{5'd10, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,         5, 1'b0};
        vecs[14] = '{5'd11, 32'd5,          32'd0,          32'hFFFF_FFFB,  32'hC0DE_000B, 2, 1'b0};
        vecs[15] = '{5'd12, 32'd0,          32'd0,          32'hFFFF_FFFF,  32'hC0DE_000C, 2, 1'b0};

        // Reset state
        #12;
        check("rst_req_ready", req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_alu_drive", {alu_a, alu_b, alu_sel} == '0, 1);
        check("rst_rsp_data", {rsp_hi, rsp_lo}, 64'h0);
        check("rst_rsp_err", err_bit, 0);
        @(negedge clk);
        clr_n = 1'b1;
        rsp_ready = 1'b1;

        // Back-to-back table; accept-to-accept gap must be latency + 1 (one IDLE cycle)
        for (int i = 0; i < 16; i++) begin
            prev_sel = alu_sel;
            prev_a   = alu_a;
            prev_acc = acc_cyc;
            send_req(vecs[i].op, vecs[i].a, vecs[i].b);
            exp_sel = vecs[i].err ? prev_sel : vecs[i].op;
            exp_a   = vecs[i].err ? prev_a : vecs[i].a;
            check($sformatf("vec%0d_alu_sel", i), alu_sel, exp_sel);
            check($sformatf("vec%0d_alu_a", i), alu_a, exp_a);
            wait_rsp(lat);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_lo", i), rsp_lo, vecs[i].lo);
            check($sformatf("vec%0d_hi", i), rsp_hi, vecs[i].hi);
            check($sformatf("vec%0d_err", i), err_bit, vecs[i].err);
            if (i > 0) begin
                check($sformatf("vec%0d_issue_gap", i), acc_cyc - prev_acc, vecs[i-1].lat + 1);
            end
        end

        // Backpressure: response held, competing request ignored
        @(negedge clk);
        rsp_ready = 1'b0;
        send_req(5'd1, 32'd2, 32'd5);
        wait_rsp(lat);
        held_lo = rsp_lo;
        check("bp_lo", held_lo, 32'hFFFF_FFFD);
        req_valid = 1'b1;
        req_op    = 5'd0;
        req_a     = 32'd40;
        req_b     = 32'd2;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("bp%0d_hold", k),
                  {rsp_valid, req_ready, busy, alu_sel, rsp_lo},
                  {1'b1, 1'b0, 1'b1, 5'd1, 32'hFFFF_FFFD});
        end
        rsp_ready = 1'b1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("bp_release_ready", req_ready, 1);
        check("bp_release_valid", rsp_valid, 0);

        // Reset in the WAIT phase of a DIV abandons the op
        send_req(5'd10, 32'd100, 32'd7);
        @(negedge clk);
        @(negedge clk);
        check("mid_wait_busy", busy, 1);
        clr_n = 1'b0;
        #1;
        check("mid_rst_outputs", {alu_a, alu_b, alu_sel, rsp_lo, rsp_hi, rsp_valid, busy}, '0);
        check("mid_rst_ready", req_ready, 1);
        @(negedge clk);
        clr_n = 1'b1;
        lat = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (rsp_valid) lat++;
        end
        check("no_rsp_after_reset", lat, 0);
        send_req(5'd0, 32'd1, 32'd1);
        wait_rsp(lat);
        check("post_rst_add_lo", rsp_lo, 32'd2);
        check("post_rst_add_latency", lat, 2);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
